// File: rtl/tick_timer_if.sv
// Control/status bundle for tick_timer: the controller drives start/stop/pause/reload/load_val
// and observes tick/done/cnt_val/busy.
interface tick_timer_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic             stop;
   logic             pause;
   logic             reload;
   logic [CNT_W-1:0] load_val;
   logic             tick;
   logic             done;
   logic [CNT_W-1:0] cnt_val;
   logic             busy;

   modport master (
      output start, stop, pause, reload, load_val,
      input  tick, done, cnt_val, busy
   );

   modport slave (
      input  start, stop, pause, reload, load_val,
      output tick, done, cnt_val, busy
   );
endinterface

// File: rtl/tick_timer.sv
// Prescaled tick down-counter with pause, one-shot or periodic expiry.
// Define TICK_TIMER_AUTORELOAD_EN to honour the reload input; otherwise every expiry is one-shot.
module tick_timer #(
   parameter int unsigned CLK_PER_TICK = 25_000_000,
   parameter int unsigned CNT_W        = 8
) (
   input logic         clk,
   input logic         rst_n,
   tick_timer_if.slave bus
);
   localparam int unsigned      PRE_W    = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;

   logic [1:0]       state;
   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] cnt;
   logic             tick_r;
   logic             done_r;
   logic             reload_en;
   logic             start_ok;
   logic             last_tick;

`ifdef TICK_TIMER_AUTORELOAD_EN
   assign reload_en = bus.reload;
`else
   assign reload_en = 1'b0;
`endif

   assign start_ok  = bus.start && (bus.load_val != '0);
   // A zero count cannot occur while busy, but treating it as the last tick keeps cnt from wrapping.
   assign last_tick = (cnt == CNT_W'(1)) || (cnt == '0);

   // Pausing only gates the prescaler, so releasing pause in the PAUSE state counts that same
   // cycle; the tick is therefore delayed by exactly the number of cycles pause was high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         pre_cnt <= '0;
         cnt     <= '0;
         tick_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         tick_r <= 1'b0;
         done_r <= 1'b0;
         if (bus.stop) begin
            state   <= IDLE;
            pre_cnt <= '0;
            cnt     <= '0;
         end else if (start_ok) begin
            state   <= RUN;
            pre_cnt <= '0;
            cnt     <= bus.load_val;
         end else if (state != IDLE) begin
            if (bus.pause) begin
               state <= PAUSE;
            end else begin
               state <= RUN;
               if (pre_cnt == PRE_LAST) begin
                  pre_cnt <= '0;
                  tick_r  <= 1'b1;
                  if (last_tick) begin
                     done_r <= 1'b1;
                     if (reload_en && (bus.load_val != '0)) begin
                        cnt <= bus.load_val;
                     end else begin
                        cnt   <= '0;
                        state <= IDLE;
                     end
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end else begin
                  pre_cnt <= pre_cnt + PRE_W'(1);
               end
            end
         end
      end
   end

   assign bus.tick    = tick_r;
   assign bus.done    = done_r;
   assign bus.cnt_val = cnt;
   assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer (CLK_PER_TICK = 4, CNT_W = 8) against a cycle-count model.
// Expectations follow TICK_TIMER_AUTORELOAD_EN when it is defined for the build.
module tb_tick_timer;
   localparam int CPT = 4;
   localparam int CW  = 8;
`ifdef TICK_TIMER_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tick_timer_if #(.CNT_W(CW)) bus ();

   tick_timer #(.CLK_PER_TICK(CPT), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int assertCount = 0;
   int failCount   = 0;
   int cyc         = 0;

   // Model: a period is mLoad ticks long; mActive counts un-paused cycles since it began.
   bit mBusy, mTick, mDone;
   int mLoad, mActive;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int modelCnt();
      return mBusy ? (mLoad - mActive / CPT) : 0;
   endfunction

   task automatic modelStep(input bit r, input bit st, input bit sp, input bit ps, input bit rl, input int lv);
      mTick = 1'b0;
      mDone = 1'b0;
      if (!r || sp) begin
         mBusy = 1'b0; mLoad = 0; mActive = 0;
      end else if (st && lv != 0) begin
         mBusy = 1'b1; mLoad = lv; mActive = 0;
      end else if (mBusy && !ps) begin
         mActive++;
         if (mActive % CPT == 0) begin
            mTick = 1'b1;
            if (mActive / CPT == mLoad) begin
               mDone   = 1'b1;
               mActive = 0;
               if (AUTO && rl && lv != 0) mLoad = lv;
               else begin mBusy = 1'b0; mLoad = 0; end
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit r, input bit st, input bit sp, input bit ps, input bit rl, input int lv);
      rst_n        = r;
      bus.start    = st;
      bus.stop     = sp;
      bus.pause    = ps;
      bus.reload   = rl;
      bus.load_val = lv[CW-1:0];
      @(posedge clk);
      modelStep(r, st, sp, ps, rl, lv);
      #1;
      cyc++;
      checkOutput($sformatf("tick@%0d", cyc), {31'd0, bus.tick}, {31'd0, mTick});
      checkOutput($sformatf("done@%0d", cyc), {31'd0, bus.done}, {31'd0, mDone});
      checkOutput($sformatf("cnt@%0d", cyc), {24'd0, bus.cnt_val}, modelCnt());
      checkOutput($sformatf("busy@%0d", cyc), {31'd0, bus.busy}, {31'd0, mBusy});
   endtask

   initial begin
      logic [31:0] tickMask, doneMask;
      int          firstTick, tickCount;
      bit          rl, ps;
      int          lv;

      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 3);
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset_cnt", {24'd0, bus.cnt_val}, 32'd0);

      // One-shot, three ticks.
      applyStimulus(1, 1, 0, 0, 0, 3);
      tickMask = 0; doneMask = 0;
      for (int i = 1; i <= 14; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 3);
         if (bus.tick) tickMask[i] = 1'b1;
         if (bus.done) doneMask[i] = 1'b1;
         if (i == 12) checkOutput("oneshot_busy12", {31'd0, bus.busy}, 32'd0);
      end
      checkOutput("oneshot_ticks", tickMask, 32'h0000_1110);
      checkOutput("oneshot_done", doneMask, 32'h0000_1000);

      // Periodic with load 2.
      applyStimulus(1, 1, 0, 0, 1, 2);
      doneMask = 0;
      for (int i = 1; i <= 26; i++) begin
         applyStimulus(1, 0, 0, 0, 1, 2);
         if (bus.done) doneMask[i] = 1'b1;
      end
      checkOutput("periodic_done", doneMask, AUTO ? 32'h0101_0100 : 32'h0000_0100);
      applyStimulus(1, 0, 1, 0, 0, 0);

      // Pause for 5 cycles once the prescaler reaches 2.
      applyStimulus(1, 1, 0, 0, 0, 5);
      firstTick = -1;
      for (int i = 1; i <= 20 && firstTick < 0; i++) begin
         applyStimulus(1, 0, 0, (i >= 3 && i <= 7), 0, 5);
         if (bus.tick) firstTick = i;
      end
      checkOutput("pause_first_tick", firstTick, 32'd9);
      checkOutput("pause_cnt_after", {24'd0, bus.cnt_val}, 32'd4);

      // Start and stop together while running.
      applyStimulus(1, 1, 0, 0, 0, 5);
      for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0, 5);
      applyStimulus(1, 1, 1, 0, 0, 5);
      checkOutput("startstop_cnt", {24'd0, bus.cnt_val}, 32'd0);
      tickCount = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 5);
         tickCount += bus.tick + bus.done;
      end
      checkOutput("startstop_quiet", tickCount, 32'd0);

      // Zero load is ignored.
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("zero_load_busy", {31'd0, bus.busy}, 32'd0);
      tickCount = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
         tickCount += bus.tick;
      end
      checkOutput("zero_load_ticks", tickCount, 32'd0);

      // Reset mid-period with five ticks remaining.
      applyStimulus(1, 1, 0, 0, 0, 7);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 7);
      checkOutput("pre_reset_cnt", {24'd0, bus.cnt_val}, 32'd5);
      applyStimulus(0, 0, 0, 0, 0, 7);
      checkOutput("midreset_outputs", {bus.tick, bus.done, bus.busy, bus.cnt_val}, 32'd0);
      tickCount = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, 0, 0, 0, 0, 7);
         tickCount += bus.tick;
      end
      checkOutput("midreset_quiet", tickCount, 32'd0);

      // Randomized traffic.
      rl = 1'b0; ps = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) rl = ~rl;
         if ($urandom_range(0, 7) == 0) ps = ~ps;
         lv = $urandom_range(0, 5);
         applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 39) == 0), ps, rl, lv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 The block SHALL have parameter CLK_PER_TICK, default 25_000_000, giving clk cycles per tick (legal range 1..2^26).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the tick counter and load value.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, a single-cycle pulse that loads load_val and runs.
REQ-006 The block SHALL have port stop, input, 1, a single-cycle pulse that aborts to idle.
REQ-007 The block SHALL have port pause, input, 1, a level that freezes counting while high.
REQ-008 The block SHALL have port reload, input, 1, a level: 1 = periodic (auto-reload), 0 = one-shot; sampled at each expiry.
REQ-009 The block SHALL have port load_val, input, CNT_W, the number of ticks per period.
REQ-010 The block SHALL have port tick, output, 1, a one-cycle pulse per elapsed tick.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse when the count reaches zero.
REQ-012 The block SHALL have port cnt_val, output, CNT_W, the number of ticks remaining.
REQ-013 The block SHALL have port busy, output, 1, high in states RUN and PAUSE.

Function
REQ-014 FSM SHALL have states IDLE, RUN and PAUSE.
REQ-015 Prescaler pre_cnt SHALL count 0..CLK_PER_TICK-1 and wrap to 0, advancing only in RUN.
REQ-016 start in IDLE with load_val != 0 SHALL, next cycle: state RUN, cnt_val = load_val, pre_cnt = 0, busy = 1.
REQ-017 start with load_val == 0 SHALL be ignored, with no state change.
REQ-018 start in RUN or PAUSE with load_val != 0 SHALL restart: cnt_val = load_val, pre_cnt = 0, state RUN.
REQ-019 stop SHALL have priority over start and pause, and next cycle give: state IDLE, cnt_val = 0, pre_cnt = 0, tick = 0, done = 0.
REQ-020 In RUN, pause high SHALL move the FSM to PAUSE next cycle; pre_cnt and cnt_val SHALL hold.
REQ-021 In PAUSE, pause low SHALL return the FSM to RUN; pre_cnt SHALL resume from its held value.
REQ-022 In RUN, pre_cnt == CLK_PER_TICK-1 (the terminal cycle) with pause low SHALL, next cycle, assert tick for exactly 1 cycle and decrement cnt_val by 1.
REQ-023 If cnt_val == 1 at the terminal cycle, next cycle done SHALL assert together with tick.
REQ-024 At that expiry, if reload = 1, cnt_val SHALL become the current load_val and the FSM SHALL stay in RUN.
REQ-025 At that expiry, if reload = 1 and load_val == 0, the FSM SHALL instead go to IDLE.
REQ-026 At that expiry, if reload = 0, cnt_val SHALL become 0, the FSM SHALL go to IDLE, and busy SHALL drop in the same cycle as done.
REQ-027 Terminal cycle coincident with pause high SHALL produce no tick; the tick SHALL occur after pause is released.
REQ-028 With CLK_PER_TICK = 1, tick SHALL assert every cycle after the first in RUN.
REQ-029 cnt_val arithmetic SHALL be unsigned CNT_W-bit and SHALL never underflow below 0.
REQ-030 load_val changes while running SHALL take effect only at the next start or reload.

Reset
REQ-031 rst_n low at a clk edge SHALL force state IDLE, pre_cnt = 0, cnt_val = 0, tick = 0, done = 0, busy = 0.
REQ-032 Reset SHALL take priority over all inputs, including mid-period and coincident with start.

Configuration
REQ-033 Macro TICK_TIMER_AUTORELOAD_EN defined SHALL give periodic behaviour per REQ-024 and REQ-025.
REQ-034 Macro TICK_TIMER_AUTORELOAD_EN undefined SHALL make the reload input ignored, with every expiry behaving as one-shot per REQ-026.

Verification (CLK_PER_TICK = 4, CNT_W = 8)
REQ-035 Bench SHALL cover: reset, load_val = 3, start, reload = 0 -> tick at cycles 4, 8, 12 after start; done with tick at 12; busy low at 12; cnt_val 3,2,1,0.
REQ-036 Bench SHALL cover: reload = 1, load_val = 2, start -> done every 8 cycles; cnt_val sequence 2,1,2,1,...; busy stays 1 (macro defined); with macro undefined, behaves as REQ-035.
REQ-037 Bench SHALL cover: pause high for 5 cycles at pre_cnt = 2 -> next tick delayed exactly 5 cycles; cnt_val unchanged during pause.
REQ-038 Bench SHALL cover: start and stop in the same cycle while RUN -> IDLE, cnt_val = 0, no tick or done afterwards.
REQ-039 Bench SHALL cover: start with load_val = 0 in IDLE -> busy stays 0, no tick.
REQ-040 Bench SHALL cover: rst_n low for 1 cycle mid-period with cnt_val = 5 -> all outputs 0 next cycle, no further ticks until start.
